axi_offset_loader: RTL and testbench
====================================

# axi_offset_loader

Sequencing controller that programs the base-offset register of the AXI address-offset adder over AXI-Lite. The block accepts an offset update request, stalls the upstream AXI master, waits for outstanding traffic to drain, writes the new offset, optionally reads it back to verify it, then releases the stall. It sits between the FEMU control logic and the AXI-Lite slave port of the address adder. Master traffic is never translated with a half-updated offset.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI-Lite address width
- C_M_AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported
- OFFSET_REG_ADDR, 32'h0000_0000, address of the offset register (register 0) in the adder's AXI-Lite space
- QUIESCE_TIMEOUT, 1023, maximum cycles spent waiting for quiesce_i; range 1..65535

Ports:
- S_AXI_ACLK, in, 1, single clock for all interfaces
- S_AXI_ARESETN, in, 1, reset; synchronous, active-low
- req_valid_i, in, 1, offset update request
- req_ready_o, out, 1, request accepted when high together with req_valid_i
- req_offset_i, in, 32, new offset value
- stall_o, out, 1, instructs the upstream AXI master to stop issuing new AW/AR
- quiesce_i, in, 1, upstream reports no outstanding AXI transactions
- done_o, out, 1, one-cycle pulse at the end of each request
- err_o, out, 2, completion status, valid while done_o is high: 00 ok, 01 bad BRESP, 10 readback fail, 11 quiesce timeout
- cur_offset_o, out, 32, last successfully loaded offset
- M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, M_AXI_AWREADY, AXI-Lite write address channel
- M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_WREADY, AXI-Lite write data channel
- M_AXI_BRESP, M_AXI_BVALID, M_AXI_BREADY, AXI-Lite write response channel
- M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_ARREADY, AXI-Lite read address channel
- M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, M_AXI_RREADY, AXI-Lite read data channel

## Operation
- FSM states: IDLE, DRAIN, WRITE, WAIT_B, READ, WAIT_R, DONE.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o: latch req_offset_i into off_q, clear the timeout counter, go to DRAIN.
- DRAIN:
  - stall_o = 1; the counter increments every cycle.
  - If quiesce_i = 1, go to WRITE.
  - Otherwise, if the counter reaches QUIESCE_TIMEOUT, set err = 11 and go to DONE. No bus access is made.
  - If quiesce_i is high on the same cycle the counter hits the limit, quiesce_i wins.
- WRITE:
  - AWVALID and WVALID are asserted together. The adder's slave requires both valid at the same time before it asserts either ready.
  - AWADDR = OFFSET_REG_ADDR, WDATA = off_q, WSTRB = 4'hF, AWPROT = ARPROT = 3'b000.
  - Each VALID stays high until its own handshake completes, then drops. The handshakes may complete on the same cycle or on different cycles.
  - When both handshakes have completed, go to WAIT_B.
- WAIT_B:
  - BREADY = 1.
  - On BVALID: if BRESP != 00, set err = 01 and go to DONE. Otherwise go to READ, or to DONE with err = 00 when readback is compiled out (see Configuration).
- READ: ARVALID = 1 with ARADDR = OFFSET_REG_ADDR, held until ARREADY; then go to WAIT_R.
- WAIT_R:
  - RREADY = 1.
  - On RVALID: if RRESP != 00 or RDATA != off_q, set err = 10; otherwise err = 00. Go to DONE.
- DONE:
  - done_o = 1 for exactly one cycle.
  - If err == 00, cur_offset_o is updated to off_q.
  - stall_o is released; next state is IDLE.
- Requests arriving outside IDLE are held off by req_ready_o = 0. No request is dropped or queued internally.
- There is no bus-side timeout. Once a VALID is asserted it is never withdrawn before its handshake; this is required by the AXI protocol.

## Timing
- Reset values:
  - state IDLE, req_ready_o 1, stall_o 0, done_o 0, err_o 00, cur_offset_o 0.
  - All M_AXI VALID and READY outputs 0; address and data outputs 0.
- All outputs are registered, except req_ready_o, which is decoded from state.
- Request-to-stall: stall_o rises the cycle after request acceptance.
- Minimum request latency with readback enabled and zero-wait-state slave behaviour matching the adder (ready one cycle after valid, response one cycle after that), from acceptance to done_o:
  - DRAIN 1 cycle (quiesce_i already high)
  - WRITE 2 cycles
  - WAIT_B 1 cycle
  - READ 2 cycles
  - WAIT_R 1 cycle
  - DONE 1 cycle
  - Total: 8 cycles; 5 cycles with readback compiled out.
- stall_o falls on the cycle after done_o. The earliest next acceptance is the cycle after done_o.
- Reset asserted mid-operation: all state returns to reset values on the next edge. In-flight AXI transactions are abandoned; the adder is reset by the same reset.

## Configuration
- Macro: AXI_OFFSET_LOADER_READBACK_EN.
- Defined: READ and WAIT_R states are present; err = 10 is possible.
- Undefined:
  - WAIT_B goes straight to DONE.
  - ARVALID and RREADY are tied to 0; ARADDR and ARPROT are tied to 0.
  - err_o is never 10.

## Test plan
- Basic load: req_offset_i = 32'h4000_0000, quiesce_i = 1, ideal slave → done_o pulse 8 cycles after acceptance, err_o = 00, cur_offset_o = 32'h4000_0000, slave register 0 reads 32'h4000_0000.
- Drain wait: quiesce_i held low for 20 cycles, then raised → AWVALID first seen the cycle after quiesce_i rises, stall_o high throughout, err_o = 00.
- Quiesce timeout: QUIESCE_TIMEOUT = 15, quiesce_i = 0 → done_o after 16 cycles in DRAIN, err_o = 11, no AW/W/AR activity, cur_offset_o unchanged.
- Split handshake: slave raises AWREADY 3 cycles before WREADY → AWVALID drops after its handshake, WVALID stays high until its own, exactly one write occurs, err_o = 00.
- Write error: slave returns BRESP = 2'b10 → err_o = 01, no AR issued, cur_offset_o unchanged.
- Readback mismatch (macro defined): slave returns RDATA = 32'h0000_0001 for off_q = 32'h0000_0000 → err_o = 10, cur_offset_o unchanged; with reset asserted during WAIT_B, all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/axi_offset_loader_if.sv
// AXI-Lite bus between the offset loader (master) and the adder's register port (slave).
// Latency: none; this is wiring only.
// Backpressure: standard AXI-Lite VALID/READY on each of the five channels.
interface axi_offset_loader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_offset_loader.sv
// Stalls upstream AXI traffic, waits for drain, writes the adder's offset register, optionally verifies it.
// Latency: accept->done_o 8 cycles with readback, 5 without, on a zero-wait slave with quiesce already high.
// Backpressure: req_ready_o only in IDLE; AXI VALIDs held until their handshake; no bus-side timeout.
// Readback verify is built in when AXI_OFFSET_LOADER_READBACK_EN is defined.
module axi_offset_loader #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] OFFSET_REG_ADDR    = {C_M_AXI_ADDR_WIDTH{1'b0}},
    parameter int                            QUIESCE_TIMEOUT    = 1023
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESETN,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [31:0]         req_offset_i,
    output logic                stall_o,
    input  logic                quiesce_i,
    output logic                done_o,
    output logic [1:0]          err_o,
    output logic [31:0]         cur_offset_o,
    axi_offset_loader_if.master m_axi
);

    localparam logic [1:0]  ERR_OK    = 2'b00;
    localparam logic [1:0]  ERR_BRESP = 2'b01;
    localparam logic [1:0]  ERR_RB    = 2'b10;
    localparam logic [1:0]  ERR_TMO   = 2'b11;
    localparam logic [15:0] TMO_LIMIT = 16'(QUIESCE_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        WRITE  = 3'd2,
        WAIT_B = 3'd3,
`ifdef AXI_OFFSET_LOADER_READBACK_EN
        READ   = 3'd4,
        WAIT_R = 3'd5,
`endif
        DONE   = 3'd6
    } state_t;

    state_t                        state_q, state_d;
    logic [31:0]                   off_q, off_d;
    logic [15:0]                   cnt_q, cnt_d;
    logic                          stall_q, stall_d;
    logic                          done_q, done_d;
    logic [1:0]                    err_q, err_d;
    logic [31:0]                   cur_q, cur_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic                          bready_q, bready_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
`ifdef AXI_OFFSET_LOADER_READBACK_EN
    logic                          arvalid_q, arvalid_d;
    logic                          rready_q, rready_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
`endif

    // Next-state and next-output decode; every register's next value defaults to its hold value.
    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        stall_d   = stall_q;
        done_d    = 1'b0;
        err_d     = err_q;
        cur_d     = cur_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
`ifdef AXI_OFFSET_LOADER_READBACK_EN
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        araddr_d  = araddr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    off_d   = req_offset_i;
                    cnt_d   = '0;
                    stall_d = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 16'd1;
                // quiesce takes priority over a timeout on the same cycle
                if (quiesce_i) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = OFFSET_REG_ADDR;
                    wdata_d   = off_q;
                    state_d   = WRITE;
                end else if (cnt_q == TMO_LIMIT) begin
                    err_d   = ERR_TMO;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            WRITE: begin
                // each VALID drops independently once its own handshake completes
                awvalid_d = awvalid_q & ~m_axi.awready;
                wvalid_d  = wvalid_q & ~m_axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (m_axi.bvalid) begin
                    bready_d = 1'b0;
                    if (m_axi.bresp != 2'b00) begin
                        err_d   = ERR_BRESP;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
`ifdef AXI_OFFSET_LOADER_READBACK_EN
                        arvalid_d = 1'b1;
                        araddr_d  = OFFSET_REG_ADDR;
                        state_d   = READ;
`else
                        err_d   = ERR_OK;
                        done_d  = 1'b1;
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef AXI_OFFSET_LOADER_READBACK_EN
            READ: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = WAIT_R;
                end
            end
            WAIT_R: begin
                if (m_axi.rvalid) begin
                    rready_d = 1'b0;
                    err_d    = ((m_axi.rresp != 2'b00) || (m_axi.rdata != off_q)) ? ERR_RB : ERR_OK;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
`endif
            DONE: begin
                stall_d = 1'b0;
                if (err_q == ERR_OK) begin
                    cur_d = off_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered datapath and bus outputs; reset abandons any in-flight AXI transaction.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            off_q     <= '0;
            cnt_q     <= '0;
            stall_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= ERR_OK;
            cur_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
`ifdef AXI_OFFSET_LOADER_READBACK_EN
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= '0;
`endif
        end else begin
            off_q     <= off_d;
            cnt_q     <= cnt_d;
            stall_q   <= stall_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cur_q     <= cur_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
`ifdef AXI_OFFSET_LOADER_READBACK_EN
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            araddr_q  <= araddr_d;
`endif
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign stall_o       = stall_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign cur_offset_o  = cur_q;

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.arprot  = 3'b000;

`ifdef AXI_OFFSET_LOADER_READBACK_EN
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;
`else
    // Read channel is idle without readback; its inputs are deliberately ignored.
    logic unused_rd;
    assign unused_rd     = ^{m_axi.arready, m_axi.rvalid, m_axi.rresp, m_axi.rdata};
    assign m_axi.araddr  = '0;
    assign m_axi.arvalid = 1'b0;
    assign m_axi.rready  = 1'b0;
`endif

endmodule

// File: tb/tb_axi_offset_loader.sv
// Bench for axi_offset_loader: AXI-Lite slave model, request driver, scoreboard of expected completions.
// Latency expectations count cycles from the accepting cycle to the done_o cycle.
// Slave READY/response timing is programmable per test.
module tb_axi_offset_loader;

    localparam int TMO = 15;
`ifdef AXI_OFFSET_LOADER_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int LAT_BASE = (RB != 0) ? 8 : 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_offset;
    logic        stall;
    logic        quiesce;
    logic        done;
    logic [1:0]  err;
    logic [31:0] cur_offset;

    always #5 clk = ~clk;

    axi_offset_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_axi ();

    axi_offset_loader #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .OFFSET_REG_ADDR    (32'h0000_0000),
        .QUIESCE_TIMEOUT    (TMO)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_offset_i  (req_offset),
        .stall_o       (stall),
        .quiesce_i     (quiesce),
        .done_o        (done),
        .err_o         (err),
        .cur_offset_o  (cur_offset),
        .m_axi         (m_axi)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- cycle counter ----------------
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- slave model ----------------
    int          aw_dly = 1, w_dly = 1, ar_dly = 1;
    logic [1:0]  bresp_cfg = 2'b00;
    bit          b_hold = 0;
    bit          rd_force = 0;
    logic [31:0] rd_force_val = '0;
    logic [31:0] reg0 = '0;
    int          awcnt, wcnt, arcnt;
    bit          aw_got, w_got;
    logic [31:0] aw_addr_l, w_data_l;
    int          aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, valid_seen_n = 0, split_n = 0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_axi.awready = 1'b0;
            m_axi.wready  = 1'b0;
            m_axi.bvalid  = 1'b0;
            m_axi.bresp   = 2'b00;
            m_axi.arready = 1'b0;
            m_axi.rvalid  = 1'b0;
            m_axi.rresp   = 2'b00;
            m_axi.rdata   = '0;
            awcnt = 0; wcnt = 0; arcnt = 0;
            aw_got = 0; w_got = 0;
        end else begin
            // responses were raised with READY already high, so they completed on the last edge
            if (m_axi.bvalid) m_axi.bvalid = 1'b0;
            if (m_axi.rvalid) m_axi.rvalid = 1'b0;
            if (m_axi.awready) begin
                m_axi.awready = 1'b0; aw_got = 1; aw_hs_n++; awcnt = 0;
            end else if (m_axi.awvalid) begin
                awcnt++;
                if (awcnt > aw_dly) begin m_axi.awready = 1'b1; aw_addr_l = m_axi.awaddr; end
            end
            if (m_axi.wready) begin
                m_axi.wready = 1'b0; w_got = 1; w_hs_n++; wcnt = 0;
            end else if (m_axi.wvalid) begin
                wcnt++;
                if (wcnt > w_dly) begin m_axi.wready = 1'b1; w_data_l = m_axi.wdata; end
            end
            if (aw_got && w_got && !b_hold) begin
                aw_got = 0; w_got = 0;
                m_axi.bvalid = 1'b1;
                m_axi.bresp  = bresp_cfg;
                if (bresp_cfg == 2'b00 && aw_addr_l == 32'h0) reg0 = w_data_l;
            end
            if (m_axi.arready) begin
                m_axi.arready = 1'b0; ar_hs_n++; arcnt = 0;
                m_axi.rvalid = 1'b1;
                m_axi.rresp  = 2'b00;
                m_axi.rdata  = rd_force ? rd_force_val : reg0;
            end else if (m_axi.arvalid) begin
                arcnt++;
                if (arcnt > ar_dly) m_axi.arready = 1'b1;
            end
            if (m_axi.awvalid || m_axi.wvalid || m_axi.arvalid) valid_seen_n++;
            if (m_axi.wvalid && !m_axi.awvalid) split_n++;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]  err;
        int          lat;
        logic [31:0] cur;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          accept_cyc = 0;
    int          done_n = 0;
    bit          pend_cur = 0;
    logic [31:0] pend_val;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pend_cur = 0;
        end else begin
            if (pend_cur) begin
                chk("cur_offset", 64'(cur_offset), 64'(pend_val));
                chk("done_pulse_width", 64'(done), 64'd0);
                chk("stall_after_done", 64'(stall), 64'd0);
                chk("ready_after_done", 64'(req_ready), 64'd1);
                pend_cur = 0;
                done_n++;
            end
            if (done) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("err", 64'(err), 64'(mon_e.err));
                    if (mon_e.lat > 0) chk("latency", 64'(cyc - accept_cyc), 64'(mon_e.lat));
                    pend_val = mon_e.cur;
                    pend_cur = 1;
                end
            end
        end
    end

    // ---------------- driver ----------------
    logic [31:0] exp_cur = '0;

    task automatic issue(input logic [31:0] off, input logic [1:0] e_err, input int e_lat);
        exp_t e;
        int   w;
        w = 0;
        while (!req_ready && w < 100) begin @(negedge clk); w++; end
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_offset = off;
        req_valid  = 1'b1;
        accept_cyc = cyc;
        if (e_err == 2'b00) exp_cur = off;
        e.err = e_err;
        e.lat = e_lat;
        e.cur = exp_cur;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        chk("stall_rise", 64'(stall), 64'd1);
        chk("ready_busy", 64'(req_ready), 64'd0);
    endtask

    task automatic wait_done(input int target);
        int w;
        w = 0;
        while (done_n < target && w < 400) begin @(negedge clk); w++; end
        chk("done_seen", 64'(done_n), 64'(target));
    endtask

    task automatic check_reset(input string p);
        chk({p, "_req_ready"}, 64'(req_ready),     64'd1);
        chk({p, "_stall"},     64'(stall),         64'd0);
        chk({p, "_done"},      64'(done),          64'd0);
        chk({p, "_err"},       64'(err),           64'd0);
        chk({p, "_cur"},       64'(cur_offset),    64'd0);
        chk({p, "_awvalid"},   64'(m_axi.awvalid), 64'd0);
        chk({p, "_wvalid"},    64'(m_axi.wvalid),  64'd0);
        chk({p, "_bready"},    64'(m_axi.bready),  64'd0);
        chk({p, "_arvalid"},   64'(m_axi.arvalid), 64'd0);
        chk({p, "_rready"},    64'(m_axi.rready),  64'd0);
        chk({p, "_awaddr"},    64'(m_axi.awaddr),  64'd0);
        chk({p, "_wdata"},     64'(m_axi.wdata),   64'd0);
        chk({p, "_araddr"},    64'(m_axi.araddr),  64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    int nd = 0;
    int v0, a0, w0, r0, s0, bad;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_offset = '0; quiesce = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // basic load
        issue(32'h4000_0000, 2'b00, LAT_BASE); nd++;
        wait_done(nd);
        chk("basic_reg0", 64'(reg0), 64'h4000_0000);
        chk("basic_aw_n", 64'(aw_hs_n), 64'd1);
        chk("basic_w_n",  64'(w_hs_n),  64'd1);
        chk("basic_ar_n", 64'(ar_hs_n), 64'(RB));

        // drain wait: quiesce raised in the 13th DRAIN cycle
        quiesce = 1'b0; bad = 0; v0 = valid_seen_n;
        issue(32'h0000_1000, 2'b00, LAT_BASE + 12); nd++;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!stall || m_axi.awvalid) bad++;
        end
        chk("drain_stall_no_aw", 64'(bad), 64'd0);
        chk("drain_no_valid", 64'(valid_seen_n - v0), 64'd0);
        quiesce = 1'b1;
        @(negedge clk);
        chk("drain_aw_after_q", 64'(m_axi.awvalid), 64'd1);
        chk("drain_stall_hold", 64'(stall), 64'd1);
        wait_done(nd);

        // quiesce rises on the very cycle the counter hits the limit: quiesce wins
        quiesce = 1'b0;
        issue(32'h0000_2000, 2'b00, LAT_BASE + TMO); nd++;
        repeat (TMO) @(negedge clk);
        quiesce = 1'b1;
        wait_done(nd);

        // quiesce timeout: 16 DRAIN cycles then DONE, no bus activity
        quiesce = 1'b0; v0 = valid_seen_n; a0 = aw_hs_n;
        issue(32'hBAD0_0000, 2'b11, TMO + 2); nd++;
        wait_done(nd);
        chk("tmo_no_valid", 64'(valid_seen_n - v0), 64'd0);
        chk("tmo_no_aw",    64'(aw_hs_n - a0),      64'd0);
        quiesce = 1'b1;

        // split handshake: AWREADY three cycles ahead of WREADY
        aw_dly = 1; w_dly = 4; a0 = aw_hs_n; w0 = w_hs_n; s0 = split_n;
        issue(32'h1234_5678, 2'b00, LAT_BASE + 3); nd++;
        wait_done(nd);
        chk("split_aw_n",   64'(aw_hs_n - a0), 64'd1);
        chk("split_w_n",    64'(w_hs_n - w0),  64'd1);
        chk("split_cycles", 64'(split_n - s0), 64'd3);
        chk("split_reg0",   64'(reg0),         64'h1234_5678);
        w_dly = 1;

        // write error response
        bresp_cfg = 2'b10; r0 = ar_hs_n; v0 = valid_seen_n;
        issue(32'h5555_0000, 2'b01, 5); nd++;
        wait_done(nd);
        chk("werr_no_ar", 64'(ar_hs_n - r0), 64'd0);
        chk("werr_reg0",  64'(reg0),         64'h1234_5678);
        bresp_cfg = 2'b00;

`ifdef AXI_OFFSET_LOADER_READBACK_EN
        // readback returns a value different from the one written
        rd_force = 1; rd_force_val = 32'h0000_0001;
        issue(32'h0000_0000, 2'b10, 8); nd++;
        wait_done(nd);
        rd_force = 0;
`endif

        // reset asserted while waiting for the write response
        b_hold = 1; bad = 0;
        issue(32'h7777_0000, 2'b00, 0);
        while (!m_axi.bready && bad < 50) begin @(negedge clk); bad++; end
        chk("midrst_in_wait_b", 64'(m_axi.bready), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        sb.delete();
        exp_cur = '0;
        b_hold = 0;
        rst_n = 1'b1;
        @(negedge clk);

        // recovery after reset
        issue(32'hCAFE_0000, 2'b00, LAT_BASE); nd++;
        wait_done(nd);
        chk("recover_reg0", 64'(reg0), 64'hCAFE_0000);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
